// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I instruction fields into machine words
// and streams them to an instruction-memory write port through a one-entry
// output buffer. A start pulse begins a load at address 0; the load ends on
// an accepted in_last bundle or when the memory capacity is exhausted.
module instr_encoder_loader #(
    parameter  int DEPTH  = 256,
    parameter  int ADDR_W = 32,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words,
    output logic [2:0]        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              buf_full;
    logic [31:0]       buf_data;
    logic              last_seen;

    logic [31:0]       enc_word;
    logic              imm_bad;
    logic              fmt_bad;
    logic [6:0]        op;
    logic [6:0]        f7;
    logic              fits12, fits13, fits21;

    logic              in_load;
    logic              drain;
    logic [CNT_W:0]    slots_used;
    logic              cap_full;
    logic              accept;
    logic              load_buf;
    logic              overflow;
    logic              last_next;
    logic              full_next;

    assign op     = {in_opcode, 2'b11};
    assign f7     = {1'b0, in_funct7b5, 5'b0};
    assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

    // Field encoder: build the machine word and flag format/immediate errors.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        enc_word = '0;
        imm_bad  = 1'b0;
        fmt_bad  = 1'b0;
        case (in_fmt)
            3'd0: enc_word = {f7, in_rs2, in_rs1, in_funct3, in_rd, op};
            3'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, op};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op};
                imm_bad = !fits12;
            end
            3'd2: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op};
                imm_bad  = !fits12;
            end
            3'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], op};
                imm_bad  = !fits13 || in_imm[0];
            end
            3'd4: enc_word = {in_imm[31:12], in_rd, op};
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
                imm_bad  = !fits21 || in_imm[0];
            end
            default: fmt_bad = 1'b1;
        endcase
    end

    // Handshake bookkeeping shared by the FSM and the datapath. Capacity counts
    // the buffered word too, so an accepted bundle always has a memory slot.
    assign in_load    = (state_q == S_LOAD);
    assign drain      = buf_full && mem_ready;
    assign slots_used = {1'b0, words} + (CNT_W + 1)'(buf_full);
    assign cap_full   = (slots_used >= (CNT_W + 1)'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign load_buf   = accept && !fmt_bad;
    assign overflow   = in_load && !last_seen && in_valid && (words == CNT_W'(DEPTH));
    assign last_next  = last_seen || (accept && in_last);
    assign full_next  = load_buf || (buf_full && !drain);

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = !last_seen && !cap_full && (!buf_full || drain);
                if (overflow || (last_next && !full_next)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Output buffer, address/word counters and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer data drives mem_wdata directly, so it is reset
            // along with the control state to keep every output at zero.
            buf_full  <= 1'b0;
            buf_data  <= '0;
            last_seen <= 1'b0;
            words     <= '0;
            mem_addr  <= '0;
            err       <= '0;
        end else if (!in_load) begin
            if (start) begin
                buf_full  <= 1'b0;
                last_seen <= 1'b0;
                words     <= '0;
                mem_addr  <= '0;
                err       <= '0;
            end
        end else begin
            if (drain) begin
                words    <= words + CNT_W'(1);
                mem_addr <= mem_addr + ADDR_W'(4);
            end
            buf_full  <= full_next;
            if (load_buf) buf_data <= enc_word;
            last_seen <= last_next;
            if (accept && fmt_bad)  err[0] <= 1'b1;
            if (load_buf && imm_bad) err[1] <= 1'b1;
            if (overflow)           err[2] <= 1'b1;
        end
    end

    assign mem_we    = buf_full;
    assign mem_wdata = buf_data;
    assign busy      = in_load;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus tasks push expected
// (address, word) pairs at acceptance; monitors pop and compare on each
// completed memory write. A second instance with DEPTH=4 covers overflow.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_s;
    logic        in_valid, in_valid_s;
    logic        in_ready, in_ready_s;
    logic        in_last;
    logic [2:0]  in_fmt;
    logic [4:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        mem_ready;
    logic        mem_we, mem_we_s;
    logic [31:0] mem_addr, mem_addr_s;
    logic [31:0] mem_wdata, mem_wdata_s;
    logic        busy, busy_s, done, done_s;
    logic [8:0]  words;
    logic [2:0]  words_s;
    logic [2:0]  err, err_s;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .words(words), .err(err)
    );

    instr_encoder_loader #(.DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .in_last(in_last), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we_s), .mem_ready(mem_ready), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .busy(busy_s), .done(done_s), .words(words_s),
        .err(err_s)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_q_s[$];
    int   wr_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   idx = 0;
    int   idx_s = 0;
    bit   toggle_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Main-instance monitor: scoreboard compare on writes, stability while stalled.
    initial begin
        exp_t        e;
        bit          stalled = 1'b0;
        logic [31:0] hold_addr = '0, hold_data = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_we", mem_we, 1);
                    check("stall_addr", mem_addr, hold_addr);
                    check("stall_data", mem_wdata, hold_data);
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", mem_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end
                    wr_cyc.push_back(cycle);
                end
                stalled   = mem_we && !mem_ready;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end
        end
    end

    // Small-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_we_s && mem_ready) begin
                if (exp_q_s.size() == 0) begin
                    check("small_unexpected_write", mem_wdata_s, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q_s.pop_front();
                    check("small_wr_addr", mem_addr_s, e.addr);
                    check("small_wr_data", mem_wdata_s, e.data);
                end
            end
        end
    end

    // Memory backpressure generator for the toggling stream.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) mem_ready = ~mem_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit to_small);
        if (to_small) begin start_s = 1'b1; idx_s = 0; end
        else          begin start   = 1'b1; idx   = 0; end
        step();
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic send(input bit to_small, input logic [2:0] fmt, input logic [4:0] op,
                        input logic [2:0] f3, input logic b5, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input bit last, input bit wr, input logic [31:0] word);
        bit   acc = 1'b0;
        int   n = 0;
        exp_t e;
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7b5 = b5;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        if (to_small) in_valid_s = 1'b1;
        else          in_valid   = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = to_small ? in_ready_s : in_ready;
            step();
            n++;
        end
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
        in_last    = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else if (wr) begin
            if (to_small) begin
                e.addr = 32'(idx_s * 4); e.data = word; exp_q_s.push_back(e); idx_s++;
            end else begin
                e.addr = 32'(idx * 4);   e.data = word; exp_q.push_back(e);   idx++;
            end
        end
    endtask

    task automatic wait_done(input bit to_small);
        int n = 0;
        while (!(to_small ? done_s : done) && n < 100) begin
            step();
            n++;
        end
        check(to_small ? "small_done_timeout" : "done_timeout", to_small ? done_s : done, 1);
    endtask

    task automatic send_stream();
        send(0, 3'd0, 5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, 32'h002081B3);
        send(0, 3'd0, 5'b01100, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, 32'h402081B3);
        send(0, 3'd2, 5'b01000, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 1, 32'h0020A423);
        send(0, 3'd4, 5'b01101, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 1, 32'h123452B7);
    endtask

    initial begin
        int sz;
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
        in_valid = 1'b0; in_valid_s = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        mem_ready = 1'b1;
        #22;
        check("reset_ctrl", {in_ready, mem_we, busy, done}, 4'b0000);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_words", words, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;
        step();

        // Single addi with in_last.
        do_start(0);
        send(0, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 1, 32'h00500093);
        wait_done(0);
        check("addi_words", words, 1);
        check("addi_err", err, 0);
        check("addi_busy", busy, 0);

        // Four-instruction stream, memory always ready: no bubbles.
        do_start(0);
        check("start_clears_done", done, 0);
        send_stream();
        wait_done(0);
        check("stream_words", words, 4);
        sz = wr_cyc.size();
        check("stream_back_to_back", sz >= 4 ? wr_cyc[sz-1] - wr_cyc[sz-4] : -1, 3);

        // Same stream with toggling backpressure.
        do_start(0);
        toggle_mode = 1'b1;
        send_stream();
        wait_done(0);
        toggle_mode = 1'b0;
        mem_ready = 1'b1;
        check("toggle_words", words, 4);
        check("toggle_err", err, 0);

        // Branch encoding, immediate range error, invalid format as last.
        do_start(0);
        send(0, 3'd3, 5'b11000, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, 1, 32'hFE000EE3);
        send(0, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 1, 32'h80000093);
        send(0, 3'd7, 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1, 0, 32'd0);
        wait_done(0);
        check("err_words", words, 2);
        check("err_flags", err, 3'b011);

        // DEPTH=4 instance: fifth bundle overflows.
        do_start(1);
        send(1, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 0, 1, 32'h00100093);
        send(1, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 0, 1, 32'h00200113);
        send(1, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 0, 1, 32'h00300193);
        send(1, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4, 0, 1, 32'h00400213);
        in_imm = 32'd5; in_rd = 5'd5; in_valid_s = 1'b1;
        wait_done(1);
        in_valid_s = 1'b0;
        check("ovf_err", err_s, 3'b100);
        check("ovf_words", words_s, 4);
        check("ovf_pending", exp_q_s.size(), 0);

        // Reset while a word is buffered and the memory stalls.
        do_start(0);
        mem_ready = 1'b0;
        send(0, 3'd1, 5'b00100, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd9, 0, 0, 32'd0);
        step();
        check("pre_reset_we", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", mem_wdata, 0);
        step();
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_ready", in_ready, 0);
            check("post_rst_idle", {busy, mem_we, done}, 3'b000);
        end
        in_valid = 1'b0;
        step();
        check("main_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
